ahb_spram_ctrl: RTL

AHB-Lite slave that fronts the single-port block RAM (`spram`, 32-bit data, active-low `cen`/`wen`, one-cycle registered read) so the core's instruction/data bus can use it as on-chip SRAM. It turns AHB address/data phases into RAM strobes and serves zero-wait reads and full-word writes. The RAM has no byte enables, so it emulates byte and halfword writes with a read-modify-write sequence.

---
 rtl/ahb_spram_pkg.sv | 38 +++
 rtl/ahb_spram_merge.sv | 19 +
 rtl/ahb_spram_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ahb_spram_pkg.sv
// rtl/ahb_spram_pkg.sv - shared states, AHB encodings and lane mask for ahb_spram_ctrl (AHB_SPRAM_UNALIGN_ERR_EN adds error states)
package ahb_spram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_DEF,
        ST_RMW_RD,
        ST_RMW_WR
`ifdef AHB_SPRAM_UNALIGN_ERR_EN
        , ST_ERR1
        , ST_ERR2
`endif
    } state_t;

    // Byte lanes touched by a write; a halfword ignores haddr[0], wide sizes cover the word
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: return 4'b0001 << addr;
            HSIZE_HALF: return addr[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_spram_merge.sv
// rtl/ahb_spram_merge.sv - byte-lane merge of new write data into an old RAM word
module ahb_spram_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [3:0]  mask,
    output logic [31:0] merged
);

    // Take each lane from the new data where the mask is set, else keep the old lane
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ahb_spram_ctrl.sv
// rtl/ahb_spram_ctrl.sv - AHB-Lite slave front end for a single-port RAM (optional AHB_SPRAM_UNALIGN_ERR_EN)
module ahb_spram_ctrl
    import ahb_spram_pkg::*;
#(
    parameter int AWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [AWIDTH+1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    state_t            state;
    state_t            next_state;
    logic [AWIDTH-1:0] addr_q;
    logic [3:0]        mask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged;
    logic              ready;
    logic              accept;
    logic              take;
    logic              ram_busy;
    logic [3:0]        new_mask;
    logic              unused_htrans;

    // Gated by rst_n so no strobe escapes while the block is held in reset
    assign accept        = rst_n & hsel & htrans[1] & hready;
    assign take          = accept & ready;
    assign ram_busy      = (state == ST_WR) || (state == ST_RMW_WR);
    assign new_mask      = lane_mask(hsize, haddr[1:0]);
    assign hreadyout     = ready;
    assign hrdata        = ram_dout;
    assign unused_htrans = htrans[0];

`ifdef AHB_SPRAM_UNALIGN_ERR_EN
    logic addr_err;
    assign addr_err = ((hsize == HSIZE_HALF) && haddr[0])
                   || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                   || (hsize > HSIZE_WORD);
`endif

    ahb_spram_merge u_merge (
        .old_word (ram_dout),
        .new_data (wdata_q),
        .mask     (mask_q),
        .merged   (merged)
    );

    // State register plus address-phase and RMW capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= next_state;
            if (take) begin
                addr_q <= haddr[AWIDTH+1:2];
                mask_q <= new_mask;
            end
            if (state == ST_RMW_RD) begin
                wdata_q <= hwdata;
            end
        end
    end

    // Data-phase RAM strobes, then a new address phase whenever the slave is ready
    always_comb begin
        next_state = state;
        ready      = 1'b1;
        hresp      = HRESP_OKAY;
        ram_cen    = 1'b1;
        ram_wen    = 1'b1;
        ram_addr   = addr_q;
        ram_din    = '0;
        case (state)
            ST_WR: begin
                ram_cen = 1'b0;
                ram_wen = 1'b0;
                ram_din = hwdata;
            end
            ST_RD_DEF: begin
                ram_cen    = 1'b0;
                ready      = 1'b0;
                next_state = ST_RD;
            end
            ST_RMW_RD: begin
                ram_cen    = 1'b0;
                ready      = 1'b0;
                next_state = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                ram_cen = 1'b0;
                ram_wen = 1'b0;
                ram_din = merged;
            end
`ifdef AHB_SPRAM_UNALIGN_ERR_EN
            ST_ERR1: begin
                ready      = 1'b0;
                hresp      = HRESP_ERROR;
                next_state = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
            end
`endif
            default: ;
        endcase
        if (ready) begin
            next_state = ST_IDLE;
            if (accept) begin
`ifdef AHB_SPRAM_UNALIGN_ERR_EN
                if (addr_err) begin
                    next_state = ST_ERR1;
                end else
`endif
                if (!hwrite) begin
                    if (ram_busy) begin
                        next_state = ST_RD_DEF;
                    end else begin
                        ram_cen    = 1'b0;
                        ram_wen    = 1'b1;
                        ram_addr   = haddr[AWIDTH+1:2];
                        next_state = ST_RD;
                    end
                end else if (new_mask == 4'b1111) begin
                    next_state = ST_WR;
                end else begin
                    next_state = ST_RMW_RD;
                end
            end
        end
    end

endmodule
